id_stage_reg: RTL

- ID-stage pipeline control and ID/EXE boundary register for the 5-stage MIPS core.
- Holds the instruction latched from IF. Uses the hazard checker's `ready` as its ready-go, and runs the valid/allowin handshake on both sides.
- Inserts a bubble into EXE on a stall and registers the decoded bundle for EXE.
- Drives the EXE-stage write_type/wnum back to the hazard checker.

---
 rtl/id_stage_reg_pkg.sv | 12 +
 rtl/id_stage_reg_pipe_hs_reg.sv | 25 ++
 rtl/id_stage_reg.sv | 107 ++++++++++
 3 files changed

// File: rtl/id_stage_reg_pkg.sv
// Shared widths and write_type encodings for the ID stage and its hazard checker.
package id_stage_reg_pkg;
  localparam int DW      = 32;
  localparam int ALUOP_W = 12;
  localparam int WT_W    = 3;

  // write_type: which stage produces the destination value (000 = no write)
  localparam logic [WT_W-1:0] WT_NONE = 3'b000;
  localparam logic [WT_W-1:0] WT_WB   = 3'b001;
  localparam logic [WT_W-1:0] WT_MEM  = 3'b010;
  localparam logic [WT_W-1:0] WT_EXE  = 3'b100;
endpackage

// File: rtl/id_stage_reg_pipe_hs_reg.sv
// Generic valid/allowin register slice: one valid bit plus a data word.
// valid advances whenever allowin is high; data only loads on an accepted live transfer.
module pipe_hs_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         allowin,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst || flush) valid <= 1'b0;
    else if (allowin) valid <= in_valid;
  end

  // Data is deliberately not cleared on a bubble; consumers must qualify with valid.
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else if (in_valid && allowin && !flush) data <= in_data;
  end
endmodule

// File: rtl/id_stage_reg.sv
// ID-stage control and ID/EXE boundary register for the 5-stage MIPS core.
// Optional stall/bubble counters are built when ID_STALL_PERF_EN is defined.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int DW      = id_stage_reg_pkg::DW,
  parameter int ALUOP_W = id_stage_reg_pkg::ALUOP_W,
  parameter int WT_W    = id_stage_reg_pkg::WT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fs_to_ds_valid,
  input  logic [DW-1:0]      fs_pc,
  input  logic [31:0]        fs_inst,
  output logic               ds_allowin,
  output logic [DW-1:0]      ds_pc,
  output logic [31:0]        ds_inst,
  output logic               ds_valid,
  input  logic [ALUOP_W-1:0] dec_alu_op,
  input  logic [DW-1:0]      dec_src1,
  input  logic [DW-1:0]      dec_src2,
  input  logic [4:0]         dec_wnum,
  input  logic [WT_W-1:0]    dec_write_type,
  input  logic               hazard_ready,
  input  logic               es_allowin,
  input  logic               flush,
  output logic               es_valid,
  output logic [DW-1:0]      es_pc,
  output logic [ALUOP_W-1:0] es_alu_op,
  output logic [DW-1:0]      es_src1,
  output logic [DW-1:0]      es_src2,
  output logic [4:0]         es_wnum,
  output logic [WT_W-1:0]    exe_write_type,
  output logic [4:0]         exe_wnum
`ifdef ID_STALL_PERF_EN
  ,
  output logic [31:0]        id_stall_cnt,
  output logic [31:0]        id_bubble_cnt
`endif
);
  localparam int DS_W = DW + 32;
  localparam int ES_W = DW + ALUOP_W + DW + DW + 5 + WT_W;

  // Handshake: a stage transfers on an edge where the producer's valid and the
  // consumer's allowin are both high; allowin is true when the stage is empty or
  // its own contents are leaving this same edge.
  logic ds_ready_go;
  logic ds_to_es_valid;
  logic [WT_W-1:0] es_write_type;
  logic [DS_W-1:0] ds_data;
  logic [ES_W-1:0] es_data;

  assign ds_ready_go    = hazard_ready;
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);

  pipe_hs_reg #(.W(DS_W)) u_fs_ds (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (fs_to_ds_valid),
    .allowin  (ds_allowin),
    .in_data  ({fs_pc, fs_inst}),
    .valid    (ds_valid),
    .data     (ds_data)
  );

  assign {ds_pc, ds_inst} = ds_data;

  // With es_allowin high and ID stalled, in_valid is 0 so a bubble enters EXE.
  pipe_hs_reg #(.W(ES_W)) u_ds_es (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (ds_to_es_valid),
    .allowin  (es_allowin),
    .in_data  ({ds_pc, dec_alu_op, dec_src1, dec_src2, dec_wnum, dec_write_type}),
    .valid    (es_valid),
    .data     (es_data)
  );

  assign {es_pc, es_alu_op, es_src1, es_src2, es_wnum, es_write_type} = es_data;

  // Gate by es_valid so stale bundle data left behind a bubble never stalls ID.
  assign exe_write_type = es_valid ? es_write_type : WT_W'(WT_NONE);
  assign exe_wnum       = es_wnum;

`ifdef ID_STALL_PERF_EN
  logic stall_ev;
  logic bubble_ev;

  assign stall_ev  = ds_valid && !hazard_ready && !flush;
  assign bubble_ev = es_allowin && ds_valid && !ds_ready_go && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_stall_cnt  <= '0;
      id_bubble_cnt <= '0;
    end else begin
      if (stall_ev && (id_stall_cnt != 32'hFFFF_FFFF))
        id_stall_cnt <= id_stall_cnt + 32'd1;
      if (bubble_ev && (id_bubble_cnt != 32'hFFFF_FFFF))
        id_bubble_cnt <= id_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule
